hc165_tx: RTL

Parallel-in, serial-out shift transmitter modelled on the 74HC165, with a valid/ready load handshake and a frame-complete pulse. It serializes a parallel word MSB-first onto a complementary serial pair (Q7/Q7N, mirroring the Q/QN output style of the HC74 flip-flop block). It is the transmit end that feeds serial-capture logic built from the HC74 flip-flops. It sits between a parallel producer and a serial line, with SER providing cascade input from an upstream stage.

---
 rtl/hc165_tx_pkg.sv | 7 +
 rtl/hc165_tx_if.sv | 7 +
 rtl/hc_bit_counter.sv | 16 +
 rtl/hc165_tx.sv | 42 ++++
 4 files changed

// File: rtl/hc165_tx_pkg.sv
// hc_pkg: shared state type and counter sizing for the hc165 transmitter.
package hc_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/hc165_tx_if.sv
// hc165_tx_if: parallel-load handshake and serial output bundle.
interface hc165_tx_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] d;
    logic pl_valid, pl_ready, shift_en, ser, q7, q7n, busy, done;
    modport master(output d, pl_valid, shift_en, ser, input pl_ready, q7, q7n, busy, done);
    modport slave(input d, pl_valid, shift_en, ser, output pl_ready, q7, q7n, busy, done);
endinterface

// File: rtl/hc_bit_counter.sv
// hc_bit_counter: loadable down-counter that saturates at zero.
module hc_bit_counter #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero,
    output logic         last
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= rst ? '0 : load ? value : (dec && !zero) ? cnt - 1'b1 : cnt;
    assign zero = cnt == '0;
    assign last = cnt == W'(1);
endmodule

// File: rtl/hc165_tx.sv
// hc165_tx: 74HC165-style parallel-in serial-out transmitter, MSB first.
module hc165_tx import hc_pkg::*; #(parameter int WIDTH = 8) (
    input  logic        clk,
    input  logic        rst,
    hc165_tx_if.slave   bus
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] sr;
    logic load, shift, last, zero, done_q;
    always_comb begin
        load     = state == IDLE && bus.pl_valid;
        shift    = state == SHIFT && bus.shift_en;
        state_nx = load ? SHIFT : ((shift && last) || zero) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= shift && last;
            if (load) sr <= bus.d;
            else if (shift) sr <= {sr[WIDTH-2:0], bus.ser};
        end
    end
    hc_bit_counter #(.W(CW)) u_cnt (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(CW'(WIDTH)),
        .dec(shift),
        .zero(zero),
        .last(last)
    );
    assign bus.pl_ready = state == IDLE;
    assign bus.busy     = state == SHIFT;
    assign bus.done     = done_q;
    assign bus.q7       = sr[WIDTH-1];
    assign bus.q7n      = ~sr[WIDTH-1];
endmodule
